// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight GPR writes in a shift scoreboard,
// resolves each ID read port to stall or a forward source, and stalls HI/LO users while MD is busy.
module hazard_scoreboard #(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int TW     = 3,
    parameter int MDW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NUM_RD*5-1:0]  id_raddr,
    input  logic [NUM_RD*TW-1:0] id_tuse,
    input  logic                 id_wen,
    input  logic [4:0]           id_waddr,
    input  logic [TW-1:0]        id_tnew,
    input  logic                 id_is_md,
    input  logic [MDW-1:0]       id_md_cyc,
    output logic                 stall,
    output logic [NUM_RD*3-1:0]  fwd_sel,
    output logic                 md_busy
);

    logic          ent_valid [DEPTH];
    logic [4:0]    ent_waddr [DEPTH];
    logic [TW-1:0] ent_tnew  [DEPTH];
    logic [MDW-1:0] md_cnt;

    logic          md_nz;
    logic          stall_raw;
    logic          accept;
    logic [NUM_RD-1:0] hit;
    logic [NUM_RD-1:0] late;
    logic [2:0]    hit_sel  [NUM_RD];
    logic [TW-1:0] hit_tnew [NUM_RD];

    assign md_nz = (md_cnt != '0);

    // Scan oldest to youngest so the youngest matching writer overrides older ones.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            hit[r]      = 1'b0;
            late[r]     = 1'b0;
            hit_sel[r]  = '0;
            hit_tnew[r] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (ent_valid[i] && (ent_waddr[i] == id_raddr[5*r +: 5]) &&
                    (id_raddr[5*r +: 5] != 5'd0)) begin
                    hit[r]      = 1'b1;
                    hit_sel[r]  = 3'(i + 1);
                    hit_tnew[r] = ent_tnew[i];
                end
            end
            late[r] = hit[r] && (hit_tnew[r] > id_tuse[TW*r +: TW]);
        end
    end

    assign stall_raw = id_valid & ((|late) | (id_is_md & md_nz));
    assign accept    = id_valid & ~stall_raw;

    assign stall   = reset & stall_raw;
    assign md_busy = reset & md_nz;

    always_comb begin
        fwd_sel = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (reset && !stall_raw && hit[r] && (hit_tnew[r] == '0)) begin
                fwd_sel[3*r +: 3] = hit_sel[r];
            end
        end
    end

    // Entries advance every cycle; a stalled ID slot enters as a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_waddr[i] <= '0;
                ent_tnew[i]  <= '0;
            end
            md_cnt <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_waddr[i] <= ent_waddr[i-1];
                ent_tnew[i]  <= (ent_tnew[i-1] != '0) ? ent_tnew[i-1] - TW'(1) : '0;
            end
            if (accept && id_wen && (id_waddr != 5'd0)) begin
                ent_valid[0] <= 1'b1;
                ent_waddr[0] <= id_waddr;
                ent_tnew[0]  <= id_tnew;
            end else begin
                ent_valid[0] <= 1'b0;
                ent_waddr[0] <= '0;
                ent_tnew[0]  <= '0;
            end
            if (accept && (id_md_cyc != '0)) begin
                md_cnt <= id_md_cyc;
            end else if (md_nz) begin
                md_cnt <= md_cnt - MDW'(1);
            end
        end
    end

endmodule
